// File: rtl/uart_reg_master.sv
// ---------------------------------------------------------------------------
// uart_reg_master
//
// Debug/host link that turns byte commands received on a UART line into
// single 32-bit register-bus reads and writes, and returns a status byte
// (plus read data for reads) on the UART transmit line.
//
// Serial format is 8N1, LSB first. Every bit lasts ClkDivider clock cycles.
//
// Command frames (address and data little-endian):
//   read  : 0x01 A0 A1 A2 A3             -> response: status R0 R1 R2 R3
//   write : 0x02 A0 A1 A2 A3 D0 D1 D2 D3 -> response: status
//   other : any other first byte         -> response: 0xFF
// status = 0x00 OK, 0x01 responder error.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   uart_rx_i    serial command input (idle high, asynchronous to clk_i)
//   uart_tx_o    serial response output (idle high)
//   reg_valid_o  request valid, held until reg_ready_i is seen
//   reg_write_o  1 = write, 0 = read
//   reg_addr_o   byte address
//   reg_wdata_o  write data
//   reg_wstrb_o  byte strobes, always 4'hF
//   reg_rdata_i  read data, valid while reg_ready_i = 1
//   reg_error_i  responder error, valid while reg_ready_i = 1
//   reg_ready_i  responder accepts/completes the request
//   busy_o       high from the opcode byte until the last response stop bit
// ---------------------------------------------------------------------------
module uart_reg_master #(
  parameter int ClkDivider    = 434,
  parameter int TimeoutCycles = 2_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        reg_valid_o,
  output logic        reg_write_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_wstrb_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_error_i,
  input  logic        reg_ready_i,
  output logic        busy_o
);

  localparam int CntW = $clog2(ClkDivider);
  localparam int TmoW = $clog2(TimeoutCycles + 1);

  localparam logic [CntW-1:0] BitLast  = CntW'(ClkDivider - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(ClkDivider / 2 - 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TimeoutCycles);

  // -------------------------------------------------------------------------
  // RX: synchroniser, start-bit validation, mid-bit sampling
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e       rx_state;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CntW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_ferr;

  // Synchroniser resets to the idle-high line level so reset release never
  // looks like a start bit.
  // NOTE: sequential state is always assigned with <=; blocking assignments
  // here would make the flops order-dependent and break the shift chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a high line means the falling edge was a glitch.
          if (rx_cnt == HalfLast) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BitLast) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            rx_bit  <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BitLast) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) rx_valid <= 1'b1;
            else         rx_ferr  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Command FSM
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_REQ, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt;
  logic            is_write;
  logic [TmoW-1:0] tmo_cnt;
  logic [39:0]     resp_buf;   // byte 0 in [7:0]; shifts down as bytes go out
  logic [2:0]      resp_last;  // index of the final response byte
  logic            tx_first;
  logic [CntW-1:0] tx_cnt;
  logic [3:0]      tx_bit;     // 0 = start, 1..8 = data, 9 = stop
  logic [2:0]      tx_byte;
  logic            tx_line;

  logic opcode_ok, tmo_hit, tx_done;

  assign opcode_ok = (rx_byte == 8'h01) || (rx_byte == 8'h02);
  assign tmo_hit   = (tmo_cnt == TmoLimit);
  assign tx_done   = !tx_first && (tx_cnt == BitLast) && (tx_bit == 4'd9) &&
                     (tx_byte == resp_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) state_d = opcode_ok ? ST_ADDR : ST_RESP;
      end
      ST_ADDR: begin
        if (rx_ferr || tmo_hit)               state_d = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) state_d = is_write ? ST_DATA : ST_REQ;
      end
      ST_DATA: begin
        if (rx_ferr || tmo_hit)               state_d = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (reg_ready_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_valid_o = (state_q == ST_REQ);
    reg_write_o = is_write;
    reg_wstrb_o = 4'hF;
    busy_o      = (state_q != ST_IDLE);
    uart_tx_o   = tx_line;
  end

  // -------------------------------------------------------------------------
  // Frame collection, request capture and response serialiser
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt    <= '0;
      is_write    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      tmo_cnt     <= '0;
      resp_buf    <= '0;
      resp_last   <= '0;
      tx_first    <= 1'b1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_byte     <= '0;
      tx_line     <= 1'b1;
    end else begin
      // Byte collection; byte_cnt wraps to 0 after each 4-byte field.
      if (state_q == ST_IDLE) begin
        byte_cnt <= '0;
        if (rx_valid && opcode_ok) is_write <= (rx_byte == 8'h02);
      end else if (rx_valid && (state_q == ST_ADDR || state_q == ST_DATA)) begin
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (state_q == ST_ADDR && rx_valid) reg_addr_o  <= {rx_byte, reg_addr_o[31:8]};
      if (state_q == ST_DATA && rx_valid) reg_wdata_o <= {rx_byte, reg_wdata_o[31:8]};

      // Inter-byte timeout, only while a frame is partially received.
      if ((state_q == ST_ADDR || state_q == ST_DATA) && !rx_valid) tmo_cnt <= tmo_cnt + 1'b1;
      else                                                         tmo_cnt <= '0;

      // Response capture.
      if (state_q == ST_IDLE && rx_valid && !opcode_ok) begin
        resp_buf  <= {32'h0, 8'hFF};
        resp_last <= 3'd0;
      end else if (state_q == ST_REQ && reg_ready_i) begin
        resp_buf  <= {reg_rdata_i, 7'h00, reg_error_i};
        resp_last <= is_write ? 3'd0 : 3'd4;
      end

      // TX: tx_line is the registered line; it is loaded with the next bit
      // value on the edge that ends the current bit. The entry cycle of RESP
      // only launches the first start bit.
      if (state_q != ST_RESP) begin
        tx_first <= 1'b1;
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_byte  <= '0;
        tx_line  <= 1'b1;
      end else if (tx_first) begin
        tx_first <= 1'b0;
        tx_line  <= 1'b0;
      end else if (tx_cnt != BitLast) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_bit <= '0;
          if (tx_byte == resp_last) begin
            tx_line <= 1'b1;
          end else begin
            // Back-to-back: next start bit follows the stop bit directly.
            tx_byte  <= tx_byte + 1'b1;
            resp_buf <= {8'h00, resp_buf[39:8]};
            tx_line  <= 1'b0;
          end
        end else begin
          tx_bit  <= tx_bit + 1'b1;
          tx_line <= (tx_bit == 4'd8) ? 1'b1 : resp_buf[tx_bit[2:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// ---------------------------------------------------------------------------
// tb_uart_reg_master
//
// Directed frames are driven onto uart_rx_i. Each stimulus pushes the
// expected register request(s) and expected TX bytes into queues; a request
// monitor and a UART TX decoder pop and compare independently.
// ---------------------------------------------------------------------------
module tb_uart_reg_master;

  localparam int Div = 8;
  localparam int Tmo = 400;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        uart_rx_i;
  logic        uart_tx_o;
  logic        reg_valid_o;
  logic        reg_write_o;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic [31:0] reg_rdata_i;
  logic        reg_error_i;
  logic        reg_ready_i;
  logic        busy_o;

  uart_reg_master #(.ClkDivider(Div), .TimeoutCycles(Tmo)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .uart_rx_i   (uart_rx_i),
    .uart_tx_o   (uart_tx_o),
    .reg_valid_o (reg_valid_o),
    .reg_write_o (reg_write_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wstrb_o (reg_wstrb_o),
    .reg_rdata_i (reg_rdata_i),
    .reg_error_i (reg_error_i),
    .reg_ready_i (reg_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          vlen;   // expected valid-high cycles; 0 = not checked
  } req_t;

  typedef logic [7:0] bytes_t[$];

  req_t       req_q[$];
  logic [7:0] tx_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  // Responder behaviour for the next request.
  int          resp_delay = 1;
  logic [31:0] resp_rdata = '0;
  logic        resp_err   = 1'b0;

  int busy_len    = 0;
  int busy_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (Div) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (Div) @(negedge clk_i);
    end
    uart_rx_i = stop_bit;
    repeat (Div) @(negedge clk_i);
    if (!stop_bit) begin
      uart_rx_i = 1'b1;
      repeat (Div) @(negedge clk_i);
    end
    uart_rx_i = 1'b1;
  endtask

  task automatic send_frame(input bytes_t f);
    foreach (f[i]) send_byte(f[i], 1'b1);
  endtask

  task automatic expect_tx(input bytes_t f);
    foreach (f[i]) tx_q.push_back(f[i]);
  endtask

  task automatic expect_req(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int vlen);
    req_t r;
    r.wr = wr; r.addr = addr; r.wdata = wdata; r.vlen = vlen;
    req_q.push_back(r);
  endtask

  // Wait until every expected item is consumed and the block is idle.
  task automatic wait_idle(input string name);
    int n = 0;
    while ((tx_q.size() != 0 || req_q.size() != 0 || busy_o) && n < 5000) begin
      @(posedge clk_i);
      n++;
    end
    check({name, " completes in budget"}, {31'b0, n < 5000}, 32'd1);
    repeat (4) @(posedge clk_i);
  endtask

  // Responder: asserts ready in the resp_delay-th cycle of valid.
  initial begin
    int vcnt = 0;
    reg_ready_i = 1'b0;
    reg_rdata_i = 32'hDEAD_DEAD;
    reg_error_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni || reg_ready_i || !reg_valid_o) begin
        vcnt        = 0;
        reg_ready_i = 1'b0;
        reg_rdata_i = 32'hDEAD_DEAD;
        reg_error_i = 1'b0;
      end else begin
        vcnt++;
        if (vcnt == resp_delay) begin
          reg_ready_i = 1'b1;
          reg_rdata_i = resp_rdata;
          reg_error_i = resp_err;
        end
      end
    end
  end

  // Request monitor.
  initial begin
    req_t        cur;
    logic        prev_v = 1'b0;
    logic        have   = 1'b0;
    logic        stable = 1'b1;
    logic [31:0] a0 = '0, d0 = '0;
    int          vrun = 0;
    forever begin
      @(posedge clk_i); #1;
      if (reg_valid_o && !prev_v) begin
        vrun = 1; stable = 1'b1; a0 = reg_addr_o; d0 = reg_wdata_o;
        if (req_q.size() == 0) begin
          n_vec++; n_miss++; have = 1'b0;
          $display("FAIL unexpected request: addr 0x%08h write %0b, expected none",
                   reg_addr_o, reg_write_o);
        end else begin
          cur  = req_q.pop_front();
          have = 1'b1;
          check("req write", {31'b0, reg_write_o}, {31'b0, cur.wr});
          check("req addr", reg_addr_o, cur.addr);
          check("req wstrb", {28'b0, reg_wstrb_o}, 32'hF);
          if (cur.wr) check("req wdata", reg_wdata_o, cur.wdata);
        end
      end else if (reg_valid_o) begin
        vrun++;
        if (reg_addr_o !== a0 || reg_wdata_o !== d0) stable = 1'b0;
      end else if (prev_v && have && cur.vlen != 0) begin
        check("valid length", vrun, cur.vlen);
        check("req stable", {31'b0, stable}, 32'd1);
      end
      prev_v = reg_valid_o;
    end
  end

  // UART TX decoder: mid-bit sampling at Div/2 after the start edge.
  initial begin
    logic [7:0] b, e;
    logic       start_v, stop_v;
    forever begin
      @(negedge uart_tx_o);
      repeat (Div / 2) @(negedge clk_i);
      start_v = uart_tx_o;
      for (int i = 0; i < 8; i++) begin
        repeat (Div) @(negedge clk_i);
        b[i] = uart_tx_o;
      end
      repeat (Div) @(negedge clk_i);
      stop_v = uart_tx_o;
      if (tx_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected tx byte: got 0x%02h, expected none", b);
      end else begin
        e = tx_q.pop_front();
        check("tx byte", {24'b0, b}, {24'b0, e});
        check("tx start bit", {31'b0, start_v}, 32'd0);
        check("tx stop bit", {31'b0, stop_v}, 32'd1);
      end
    end
  end

  // Busy pulse width tracker.
  initial begin
    int run = 0;
    forever begin
      @(posedge clk_i); #1;
      if (busy_o) run++;
      else if (run != 0) begin
        busy_len = run;
        busy_pulses++;
        run = 0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t f;
    int     pulses0;
    int     n;

    rst_ni    = 1'b0;
    uart_rx_i = 1'b1;
    repeat (3) @(posedge clk_i); #1;

    check("reset uart_tx_o", {31'b0, uart_tx_o}, 32'd1);
    check("reset reg_valid_o", {31'b0, reg_valid_o}, 32'd0);
    check("reset reg_write_o", {31'b0, reg_write_o}, 32'd0);
    check("reset busy_o", {31'b0, busy_o}, 32'd0);
    check("reset reg_addr_o", reg_addr_o, 32'd0);
    check("reset reg_wdata_o", reg_wdata_o, 32'd0);
    check("reset reg_wstrb_o", {28'b0, reg_wstrb_o}, 32'hF);

    @(negedge clk_i); rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);

    // Write 0xDEADBEEF to 0x20000010, ready after 3 cycles.
    resp_delay = 3; resp_err = 1'b0; resp_rdata = 32'h0BAD_F00D;
    expect_req(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 3);
    f = '{8'h00}; expect_tx(f);
    f = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(f);
    wait_idle("write");

    // Read 0x20000000, ready with valid.
    resp_delay = 1; resp_err = 1'b0; resp_rdata = 32'h1234_5678;
    expect_req(1'b0, 32'h2000_0000, 32'h0, 1);
    f = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12}; expect_tx(f);
    f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame(f);
    wait_idle("read");

    // Errored read.
    resp_delay = 1; resp_err = 1'b1; resp_rdata = 32'h0;
    expect_req(1'b0, 32'h2000_0000, 32'h0, 1);
    f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00}; expect_tx(f);
    f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame(f);
    wait_idle("errored read");

    // Bad opcode: FF back, busy for one entry cycle plus one 10-bit byte.
    pulses0 = busy_pulses;
    f = '{8'hFF}; expect_tx(f);
    send_byte(8'h7E, 1'b1);
    wait_idle("bad opcode");
    check("bad opcode busy pulses", busy_pulses - pulses0, 32'd1);
    check("bad opcode busy width", busy_len, 10 * Div + 1);

    // Partial frame then timeout: silent drop, then a full read.
    f = '{8'h01, 8'h00, 8'h00};
    send_frame(f);
    check("busy during partial frame", {31'b0, busy_o}, 32'd1);
    repeat (Tmo + 10) @(posedge clk_i); #1;
    check("busy after timeout", {31'b0, busy_o}, 32'd0);
    resp_delay = 2; resp_err = 1'b0; resp_rdata = 32'hA5A5_0F0F;
    expect_req(1'b0, 32'h0000_0004, 32'h0, 2);
    f = '{8'h00, 8'h0F, 8'h0F, 8'hA5, 8'hA5}; expect_tx(f);
    f = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00};
    send_frame(f);
    wait_idle("read after timeout");

    // Framing error mid-frame aborts without a request.
    f = '{8'h02, 8'h10, 8'h00};
    send_frame(f);
    send_byte(8'h55, 1'b0);
    repeat (20) @(posedge clk_i); #1;
    check("busy after framing error", {31'b0, busy_o}, 32'd0);
    repeat (100) @(posedge clk_i);

    // Reset during REQ.
    resp_delay = 1000; resp_err = 1'b0; resp_rdata = 32'h0;
    expect_req(1'b0, 32'h2000_0000, 32'h0, 0);
    f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame(f);
    n = 0;
    while (!reg_valid_o && n < 200) begin @(posedge clk_i); n++; end
    check("reached REQ before reset", {31'b0, reg_valid_o}, 32'd1);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b0; #1;
    check("async reset reg_valid_o", {31'b0, reg_valid_o}, 32'd0);
    check("async reset uart_tx_o", {31'b0, uart_tx_o}, 32'd1);
    check("async reset busy_o", {31'b0, busy_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);

    resp_delay = 2; resp_err = 1'b0; resp_rdata = 32'hCAFE_F00D;
    expect_req(1'b0, 32'h2000_0000, 32'h0, 2);
    f = '{8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA}; expect_tx(f);
    f = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame(f);
    wait_idle("read after reset");

    repeat (20) @(posedge clk_i);
    check("tx queue drained", tx_q.size(), 32'd0);
    check("req queue drained", req_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
